// File: rtl/sw_debounce_if.sv
// sw_debounce_if: raw switch levels in, debounced levels and edge strobes out
interface sw_debounce_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    modport master (output sw_in, input sw_out, rise, fall);
    modport slave (input sw_in, output sw_out, rise, fall);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus per-bit stability counter with rise/fall strobes
module sw_debounce #(
    parameter int WIDTH = 2,
    parameter int CNT_MAX = 1000000
) (
    input logic clk,
    input logic rst,
    sw_debounce_if.slave bus
);
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);
    logic [WIDTH-1:0] s1, s2;
    logic [WIDTH-1:0] sw_q, rise_q, fall_q;
    logic [CNT_W-1:0] cnt [WIDTH];
    assign bus.sw_out = sw_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    // bring the asynchronous switch levels into the clk domain; only s2 is used downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.sw_in;
            s2 <= s1;
        end
    end
    // per bit: count while s2 disagrees with the output, accept after CNT_MAX agreeing edges
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (s2[i] == sw_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    cnt[i] <= '0;
                    sw_q[i] <= s2[i];
                    rise_q[i] <= s2[i];
                    fall_q[i] <= ~s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input conditioning stage for the board slide switches.
- Synchronises each raw switch bit into the clock domain and debounces it with a per-bit stability counter.
- Emits clean levels plus one-cycle rise/fall strobes.
- Sits directly upstream of the two-input logic-gate demo block: sw_out[0] drives its a input and sw_out[1] drives its b input.

Parameters:
- WIDTH, 2, number of independent switch bits.
- CNT_MAX, 1000000, cycles the synchronised input must differ from sw_out before sw_out updates (10 ms at 100 MHz). Legal range is CNT_MAX >= 2.
- CNT_W, $clog2(CNT_MAX), per-bit counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- sw_in  input  WIDTH  raw asynchronous switch levels.
- sw_out  output  WIDTH  debounced levels, registered.
- rise  output  WIDTH  one-cycle strobe per bit on a 0->1 change of sw_out, registered.
- fall  output  WIDTH  one-cycle strobe per bit on a 1->0 change of sw_out, registered.

Behaviour:
- Reset: the one clock is clk; reset is synchronous and active-high on rst.
  - While rst=1 at a clock edge, clear to 0: sync stage 1, sync stage 2, all counters, sw_out, rise and fall.
  - No asynchronous reset path.
- Synchroniser: a two-flop chain per bit, sw_in -> s1 -> s2. Only s2 feeds the debounce logic.
- Per-bit state (two states, implied by the counter):
  - IDLE, when s2 == sw_out[i]: counter is held at 0.
  - COUNT, when s2 != sw_out[i]: counter increments by 1 each edge.
- Any edge where s2 == sw_out[i] returns the bit to IDLE and clears its counter. A glitch restarts qualification from zero.
- Accept: at an edge where s2 != sw_out[i] and counter == CNT_MAX-1:
  - sw_out[i] <= s2 and counter <= 0.
  - rise[i] <= s2, fall[i] <= ~s2.
- rise and fall are 0 on every other edge, so each strobe is high exactly one cycle, coincident with the sw_out change.
- Latency: once sw_in[i] changes and holds, sw_out[i] changes on the (CNT_MAX+2)th rising edge, counting the first edge that samples the new level as edge 1.
- Minimum accepted pulse: the input must hold for exactly CNT_MAX cycles as seen at s2.
  - Held CNT_MAX cycles: accepted.
  - Held CNT_MAX-1 cycles: rejected, no strobe.
- Bits are fully independent. Simultaneous changes on several bits qualify and strobe in the same cycle; mixed rise/fall in one cycle is legal.
- The counter never exceeds CNT_MAX-1; there is no wrap-around.
- Reset mid-count discards progress. After release, a held input needs the full CNT_MAX+2 edges again.
- rise[i] and fall[i] are never both 1.
- sw_out never changes without the matching strobe.

Test Plan (CNT_MAX=4, WIDTH=2):
- Reset with input high: rst=1 for 3 edges with sw_in=2'b11.
  -> sw_out=2'b00 and rise=fall=0 during reset.
  -> After release, sw_out=2'b11 on the 6th edge and rise=2'b11 for exactly that one cycle.
- Bounce on bit 0: sw_in[0] toggles every 2 cycles for 20 cycles, then holds 1.
  -> sw_out[0] stays 0 and no strobe during the bounce.
  -> sw_out[0]=1 and a single rise[0] pulse on the 6th edge after the final transition.
- Pulse-width threshold: from 0, sw_in[1] is high for 3 cycles then low.
  -> No change on sw_out[1], rise[1] or fall[1].
  -> Repeat with a 4-cycle pulse: sw_out[1] rises, then falls 4+2 edges after the input drops; rise[1] and fall[1] each pulse once.
- Mixed simultaneous change: with sw_out=2'b10, apply sw_in=2'b01 on one edge.
  -> On the same cycle 6 edges later: sw_out=2'b01, rise=2'b01, fall=2'b10, with only one strobe cycle.
- Reset mid-count: sw_in=2'b01, rst pulsed for 1 cycle at edge 4.
  -> sw_out[0] stays 0 through the reset.
  -> It rises only 6 edges after the reset release edge.
- Falling path: from sw_out=2'b11, apply sw_in=2'b00.
  -> fall=2'b11 for one cycle, sw_out=2'b00, rise stays 0.
